// File: rtl/melody_recorder.sv
// Live key-press recorder producing the 6-bit note-code melody consumed by the auto-play block.
// Codes are packed LSB-first, one per committed note or rest.
module melody_recorder #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int T16_MAX    = 2,
  parameter int T8_MAX     = 4,
  parameter int REST_TICKS = 4,
  parameter int MAX_NOTES  = 333
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   modechange,
  input  logic [6:0]             keys,
  input  logic                   isHight,
  input  logic                   isLow,
  input  logic                   rec_start,
  input  logic                   rec_stop,
  output logic [6*MAX_NOTES-1:0] melody,
  output logic [31:0]            melody_length,
  output logic                   recording,
  output logic                   full,
  output logic                   done,
  output logic [5:0]             cur_code
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_NOTE, S_GAP, S_DONE} state_t;

  state_t                   r_state;
  logic [6*MAX_NOTES-1:0]   r_melody;
  logic [31:0]              r_len;
  logic                     r_full;
  logic                     r_done;
  logic [DIV_W-1:0]         r_div;
  logic [7:0]               r_held;
  logic [7:0]               r_gap;
  logic [2:0]               r_p;
  logic [1:0]               r_oct;

  logic                     w_valid;
  logic [2:0]               w_p;
  logic [1:0]               w_oct;
  logic                     w_tick;
  logic [7:0]               w_held_eff;
  logic [5:0]               w_note_code;
  logic [5:0]               w_commit_code;
  logic                     w_commit;
  logic                     w_last;

  // Duration class index from held ticks: 8th -> 0, quarter -> 1, 16th -> 2.
  function automatic logic [1:0] f_dur(input logic [7:0] held);
    if (held <= 8'(T16_MAX))     return 2'd2;
    else if (held <= 8'(T8_MAX)) return 2'd0;
    else                         return 2'd1;
  endfunction

  // code = 1 + 7*(3*oct + dur) + p, max 63 so 6-bit arithmetic never wraps.
  function automatic logic [5:0] f_code(input logic [2:0] p, input logic [1:0] oct,
                                        input logic [1:0] dur);
    logic [5:0] grp;
    grp = 6'd3 * {4'd0, oct} + {4'd0, dur};
    return 6'd1 + 6'd7 * grp + {3'd0, p};
  endfunction

  // Key decode: pitch of the single pressed key (do = 0 ... si = 6).
  always_comb begin
    w_p = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (keys[i]) w_p = 3'(6 - i);
    end
  end

  assign w_valid = $onehot(keys);
  assign w_oct   = (isHight & ~isLow) ? 2'd2 : ((isLow & ~isHight) ? 2'd1 : 2'd0);
  assign w_tick  = (r_div == DIV_W'(TICK_DIV - 1));

  // A tick landing on the release edge still belongs to the note being committed.
  assign w_held_eff    = (w_tick && r_held != 8'hFF) ? r_held + 8'd1 : r_held;
  assign w_note_code   = f_code(r_p, r_oct, f_dur(w_held_eff));
  assign w_commit_code = (r_state == S_GAP) ? 6'd0 : w_note_code;
  assign w_last        = (r_len == 32'(MAX_NOTES - 1));

  assign w_commit = !rec_start &&
                    ((r_state == S_NOTE && (rec_stop || !w_valid || w_p != r_p)) ||
                     (r_state == S_GAP && !rec_stop && !w_valid && w_tick &&
                      r_gap == 8'(REST_TICKS - 1)));

  // Recorder FSM: note/rest timing, commit into the melody buffer, full/done handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_melody <= '0;
      r_len    <= '0;
      r_full   <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_held   <= '0;
      r_gap    <= '0;
      r_p      <= '0;
      r_oct    <= '0;
    end else if (modechange) begin
      r_state  <= S_IDLE;
      r_melody <= '0;
      r_len    <= '0;
      r_full   <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_held   <= '0;
      r_gap    <= '0;
      r_p      <= '0;
      r_oct    <= '0;
    end else begin
      r_done <= 1'b0;
      r_div  <= w_tick ? '0 : r_div + DIV_W'(1);
      if (rec_start) begin
        r_state  <= S_WAIT;
        r_melody <= '0;
        r_len    <= '0;
        r_full   <= 1'b0;
        r_div    <= '0;
        r_held   <= '0;
        r_gap    <= '0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (rec_stop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_valid) begin
              r_state <= S_NOTE;
              r_p     <= w_p;
              r_oct   <= w_oct;
              r_held  <= '0;
              r_div   <= '0;
            end
          end
          S_NOTE: begin
            if (rec_stop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (!w_valid) begin
              r_state <= S_GAP;
              r_gap   <= '0;
              r_div   <= '0;
            end else if (w_p != r_p) begin
              r_p    <= w_p;
              r_oct  <= w_oct;
              r_held <= '0;
              r_div  <= '0;
            end else begin
              r_held <= w_held_eff;
            end
          end
          S_GAP: begin
            if (rec_stop) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_valid) begin
              r_state <= S_NOTE;
              r_p     <= w_p;
              r_oct   <= w_oct;
              r_held  <= '0;
              r_div   <= '0;
            end else if (w_tick) begin
              r_gap <= (r_gap == 8'(REST_TICKS - 1)) ? 8'd0 : r_gap + 8'd1;
            end
          end
          default: ;
        endcase
        if (w_commit) begin
          for (int i = 0; i < MAX_NOTES; i++) begin
            if (r_len == 32'(i)) r_melody[6*i +: 6] <= w_commit_code;
          end
          r_len <= r_len + 32'd1;
          if (w_last) begin
            r_full  <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign melody        = r_melody;
  assign melody_length = r_len;
  assign full          = r_full;
  assign done          = r_done;
  assign recording     = (r_state == S_WAIT) || (r_state == S_NOTE) || (r_state == S_GAP);
  assign cur_code      = (r_state == S_NOTE) ? f_code(r_p, r_oct, f_dur(r_held)) : 6'd0;

endmodule
